// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 4-digit seven-segment driver.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 0 is the rightmost entry: digit 0 -> 7'h40 ... digit 9 -> 7'h10
  localparam logic [9:0][6:0] SEG_PAT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/disp_bcd_mux_bcd2sseg.sv
// Combinational 8421 digit to active-low seven-segment decoder.
// Codes 10..15 are shown as a dash so corrupt digits are visible.
module bcd2sseg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) seg = SEG_PAT[bcd];
  end

endmodule

// File: rtl/disp_bcd_mux.sv
// Double-buffered, time-multiplexed 4-digit seven-segment driver with
// leading-zero blanking and decimal point. Optional PWM dimming: DISP_BRIGHTNESS_PWM_EN.
module disp_bcd_mux
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic       update,
  input  logic       dp_en,
  input  logic [1:0] dp_pos,
  input  logic       blank_lz,
`ifdef DISP_BRIGHTNESS_PWM_EN
  input  logic [3:0] brightness,
`endif
  output logic [6:0] sseg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  logic [CNT_W-1:0]                cnt_reg;
  digit_idx_t                      idx_reg;
  logic [NUM_DIGITS-1:0][3:0]      pend_bcd_reg, disp_bcd_reg;
  logic                            pend_dp_en_reg, disp_dp_en_reg;
  digit_idx_t                      pend_dp_pos_reg, disp_dp_pos_reg;
  logic                            blank_lz_reg;
  logic [6:0]                      sseg_reg, sseg_next;
  logic [3:0]                      an_reg, an_next;
  logic                            dp_reg, dp_next;
  logic                            frame_done_reg;

  logic                            tick;
  logic                            frame_end;
  logic [3:0]                      cur_digit;
  logic [6:0]                      cur_seg;
  logic [NUM_DIGITS-1:0]           lead_zero;
  logic                            slot_blank;
  logic                            pwm_on;

  assign tick      = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx_reg == digit_idx_t'(NUM_DIGITS - 1));
  assign cur_digit = disp_bcd_reg[idx_reg];

  // lead_zero[gi]: digit gi and every more significant digit are zero
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lead_zero[gi] = ~|disp_bcd_reg[NUM_DIGITS-1:gi];
  end

  bcd2sseg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

`ifdef DISP_BRIGHTNESS_PWM_EN
  localparam int SUB_DIV = REFRESH_DIV / 16;
  logic [CNT_W-1:0] sub_cnt_reg;
  logic [3:0]       sub_phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt_reg   <= '0;
      sub_phase_reg <= '0;
    end else if (tick) begin
      sub_cnt_reg   <= '0;
      sub_phase_reg <= '0;
    end else if (sub_cnt_reg == CNT_W'(SUB_DIV - 1)) begin
      sub_cnt_reg   <= '0;
      sub_phase_reg <= sub_phase_reg + 4'd1;
    end else begin
      sub_cnt_reg   <= sub_cnt_reg + 1'b1;
    end
  end

  assign pwm_on = (sub_phase_reg <= brightness);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    slot_blank = 1'b0;
    if (blank_lz_reg && (idx_reg != 2'd0) && lead_zero[idx_reg]) slot_blank = 1'b1;
    if (disp_dp_en_reg && (idx_reg <= disp_dp_pos_reg))          slot_blank = 1'b0;

    an_next   = 4'b1111;
    sseg_next = SEG_BLANK;
    dp_next   = 1'b1;
    if (!slot_blank && pwm_on) begin
      an_next[idx_reg] = 1'b0;
      sseg_next        = cur_seg;
      dp_next          = !(disp_dp_en_reg && (idx_reg == disp_dp_pos_reg));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      pend_bcd_reg    <= '0;
      disp_bcd_reg    <= '0;
      pend_dp_en_reg  <= 1'b0;
      disp_dp_en_reg  <= 1'b0;
      pend_dp_pos_reg <= '0;
      disp_dp_pos_reg <= '0;
      blank_lz_reg    <= 1'b0;
      an_reg          <= 4'b1111;
      sseg_reg        <= SEG_BLANK;
      dp_reg          <= 1'b1;
      frame_done_reg  <= 1'b0;
    end else begin
      cnt_reg        <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) idx_reg <= idx_reg + 2'd1;
      blank_lz_reg   <= blank_lz;
      frame_done_reg <= frame_end;
      // Display copies the pending value as it stood before this edge,
      // so an update coinciding with the boundary waits one more frame.
      if (frame_end) begin
        disp_bcd_reg    <= pend_bcd_reg;
        disp_dp_en_reg  <= pend_dp_en_reg;
        disp_dp_pos_reg <= pend_dp_pos_reg;
      end
      if (update) begin
        pend_bcd_reg    <= {bcd3, bcd2, bcd1, bcd0};
        pend_dp_en_reg  <= dp_en;
        pend_dp_pos_reg <= dp_pos;
      end
      an_reg   <= an_next;
      sseg_reg <= sseg_next;
      dp_reg   <= dp_next;
    end
  end

  assign an         = an_reg;
  assign sseg       = sseg_reg;
  assign dp         = dp_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_disp_bcd_mux.sv
// Directed self-checking bench for disp_bcd_mux with REFRESH_DIV=16.
// Expected segment/anode values are hand-computed constants.
module tb_disp_bcd_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       update, dp_en, blank_lz;
  logic [1:0] dp_pos;
  logic [6:0] sseg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;
`ifdef DISP_BRIGHTNESS_PWM_EN
  logic [3:0] brightness = 4'd15;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  disp_bcd_mux #(.REFRESH_DIV(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .update     (update),
    .dp_en      (dp_en),
    .dp_pos     (dp_pos),
    .blank_lz   (blank_lz),
`ifdef DISP_BRIGHTNESS_PWM_EN
    .brightness (brightness),
`endif
    .sseg       (sseg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic load(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                      input logic [3:0] d0, input logic de, input logic [1:0] dpp,
                      input logic blz);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
    dp_en = de; dp_pos = dpp; blank_lz = blz;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Returns on the negedge where frame_done is high (cycle after the boundary)
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Checks first cycle of each slot of the next frame; returns in slot 3
  task automatic check_frame(input string name, input logic [3:0][3:0] ean,
                             input logic [3:0][6:0] esg, input logic [3:0] edp);
    wait_frame();
    @(negedge clk);
    chk({name, "_fd_pulse"}, {31'd0, frame_done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) repeat (16) @(negedge clk);
      chk($sformatf("%s_an%0d", name, k),   {28'd0, an},   {28'd0, ean[k]});
      chk($sformatf("%s_sseg%0d", name, k), {25'd0, sseg}, {25'd0, esg[k]});
      chk($sformatf("%s_dp%0d", name, k),   {31'd0, dp},   {31'd0, edp[k]});
    end
    $display("frame %s checked (%0d checks so far)", name, n_checks);
  endtask

  initial begin
    rst_n = 1'b0;
    {bcd0, bcd1, bcd2, bcd3} = '0;
    update = 1'b0; dp_en = 1'b0; dp_pos = 2'd0; blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_sseg", {25'd0, sseg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_first_an", {28'd0, an}, 32'hF);
    @(negedge clk);
    chk("rel_d0_an", {28'd0, an}, 32'hE);
    chk("rel_d0_sseg", {25'd0, sseg}, 32'h40);
    $display("reset sequence checked");

    // 1,2,3,4 without blanking
    load(4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 2'd0, 1'b0);
    check_frame("d1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111);

    // Value 50 with leading-zero blanking
    load(4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 2'd0, 1'b1);
    check_frame("lz50", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);

    // Decimal point on digit 2 keeps it from being blanked
    load(4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 2'd2, 1'b1);
    check_frame("lz50dp2", {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011);

    // Update coinciding with the frame boundary (we are at slot 3, cycle 1)
    load(4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 2'd0, 1'b0);
    repeat (13) @(negedge clk);
    bcd0 = 4'd7;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk("coin_fd", {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    chk("coin_old_an", {28'd0, an}, 32'hE);
    chk("coin_old_sseg", {25'd0, sseg}, 32'h30);
    $display("coincident update: old pending shown");
    check_frame("coin_new", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111);

    // Dash for an illegal code; non-zero MSB suppresses blanking
    load(4'hC, 4'd0, 4'd0, 4'd1, 1'b0, 2'd0, 1'b1);
    check_frame("dash", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h3F, 7'h40, 7'h40, 7'h79}, 4'b1111);

    // Asynchronous reset at idx=2, cnt=9
    wait_frame();
    repeat (41) @(negedge clk);
    chk("prerst_an", {28'd0, an}, 32'hB);
    blank_lz = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {28'd0, an}, 32'hF);
    chk("arst_sseg", {25'd0, sseg}, 32'h7F);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_d0_an", {28'd0, an}, 32'hE);
    chk("post_d0_sseg", {25'd0, sseg}, 32'h40);
    repeat (16) @(negedge clk);
    chk("post_d1_an", {28'd0, an}, 32'hD);
    chk("post_d1_sseg", {25'd0, sseg}, 32'h40);
    $display("mid-frame reset checked");

`ifdef DISP_BRIGHTNESS_PWM_EN
    begin
      int on_cnt;
      load(4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 2'd0, 1'b0);
      wait_frame();
      brightness = 4'd3;
      repeat (2) @(negedge clk);
      on_cnt = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (an != 4'hF) on_cnt++;
      end
      chk("pwm_b3", on_cnt, 32'd16);
      brightness = 4'd15;
      repeat (2) @(negedge clk);
      on_cnt = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (an != 4'hF) on_cnt++;
      end
      chk("pwm_b15", on_cnt, 32'd64);
      $display("brightness checked");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
